// File: rtl/palette_write_ctrl.sv
// Palette BRAM write sequencer: arbitrates a buffered host write stream and a
// range-fill engine onto the single palette write port, optionally only in blanking.
module palette_write_ctrl #(
   parameter int FIFO_AW = 4
) (
   input  logic               clk_pix,
   input  logic               rst_pix,
   input  logic               de,
   input  logic               blank_only,
   input  logic               host_valid,
   output logic               host_ready,
   input  logic [7:0]         host_idx,
   input  logic [23:0]        host_rgb,
   input  logic               fill_start,
   input  logic [7:0]         fill_first,
   input  logic [7:0]         fill_last,
   input  logic [23:0]        fill_rgb,
   output logic               fill_busy,
   output logic               pal_we,
   output logic [7:0]         pal_waddr,
   output logic [23:0]        pal_wdata,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {FILL_IDLE = 1'b0, FILL_RUN = 1'b1} fill_state_t;

   logic [31:0]        fifo_mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [FIFO_AW:0]   level_r;
   fill_state_t        state_r, state_nxt_s;
   logic [7:0]         fill_ptr_r;
   logic [8:0]         fill_remain_r;
   logic [23:0]        fill_rgb_r;
   logic               rr_host_r;
   logic               pal_we_r;
   logic [7:0]         pal_waddr_r;
   logic [23:0]        pal_wdata_r;

   logic        host_ready_s, push_s, eligible_s, h_req_s, f_req_s;
   logic        grant_h_s, grant_f_s;
   logic [31:0] fifo_head_s;

   assign host_ready_s = (level_r != LVL_FULL);
   assign push_s       = host_valid && host_ready_s;
   assign eligible_s   = !blank_only || !de;
   assign h_req_s      = (level_r != {(FIFO_AW+1){1'b0}});
   assign f_req_s      = (state_r == FILL_RUN);
   assign fifo_head_s  = fifo_mem_r[rd_ptr_r];

   // Single-grant arbiter; under contention the side not served last time wins.
   always_comb begin
      grant_h_s = 1'b0;
      grant_f_s = 1'b0;
      if (eligible_s) begin
         if (h_req_s && f_req_s) begin
            if (rr_host_r) begin
               grant_h_s = 1'b1;
            end else begin
               grant_f_s = 1'b1;
            end
         end else if (h_req_s) begin
            grant_h_s = 1'b1;
         end else if (f_req_s) begin
            grant_f_s = 1'b1;
         end else begin
            grant_h_s = 1'b0;
         end
      end else begin
         grant_h_s = 1'b0;
      end
   end

   // Host FIFO storage; no reset needed, occupancy is tracked by level_r.
   always_ff @(posedge clk_pix) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= {host_idx, host_rgb};
      end
   end

   // Host FIFO pointers and occupancy.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         wr_ptr_r <= {FIFO_AW{1'b0}};
         rd_ptr_r <= {FIFO_AW{1'b0}};
         level_r  <= {(FIFO_AW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (grant_h_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, grant_h_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

   // Fill engine next-state: the grant that issues the last write ends the run.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FILL_IDLE: begin
            if (fill_start) state_nxt_s = FILL_RUN;
            else            state_nxt_s = FILL_IDLE;
         end
         FILL_RUN: begin
            if (grant_f_s && (fill_remain_r == 9'd1)) state_nxt_s = FILL_IDLE;
            else                                      state_nxt_s = FILL_RUN;
         end
         default: state_nxt_s = FILL_IDLE;
      endcase
   end

   // Fill engine state register.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) state_r <= FILL_IDLE;
      else         state_r <= state_nxt_s;
   end

   // Fill range datapath; a wrapped range is handled by mod-256 arithmetic.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         fill_ptr_r    <= 8'd0;
         fill_remain_r <= 9'd0;
         fill_rgb_r    <= 24'd0;
      end else if ((state_r == FILL_IDLE) && fill_start) begin
         fill_ptr_r    <= fill_first;
         fill_remain_r <= {1'b0, fill_last - fill_first} + 9'd1;
         fill_rgb_r    <= fill_rgb;
      end else if (grant_f_s) begin
         fill_ptr_r    <= fill_ptr_r + 8'd1;
         fill_remain_r <= fill_remain_r - 9'd1;
      end
   end

   // Round-robin pointer and registered palette write port.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         rr_host_r   <= 1'b1;
         pal_we_r    <= 1'b0;
         pal_waddr_r <= 8'd0;
         pal_wdata_r <= 24'd0;
      end else begin
         pal_we_r <= grant_h_s || grant_f_s;
         if (grant_h_s) begin
            rr_host_r   <= 1'b0;
            pal_waddr_r <= fifo_head_s[31:24];
            pal_wdata_r <= fifo_head_s[23:0];
         end else if (grant_f_s) begin
            rr_host_r   <= 1'b1;
            pal_waddr_r <= fill_ptr_r;
            pal_wdata_r <= fill_rgb_r;
         end
      end
   end

   assign host_ready = host_ready_s;
   assign fill_busy  = (state_r == FILL_RUN);
   assign pal_we     = pal_we_r;
   assign pal_waddr  = pal_waddr_r;
   assign pal_wdata  = pal_wdata_r;
   assign fifo_level = level_r;

endmodule

// File: tb/tb_palette_write_ctrl.sv
// Self-checking bench for palette_write_ctrl: randomized host/fill traffic
// compared against a queue-based model of the expected palette write stream.
module tb_palette_write_ctrl;
   localparam int AW = 4;

   logic          clk_pix = 1'b0;
   logic          rst_pix, de, blank_only, host_valid, host_ready, fill_start, fill_busy, pal_we;
   logic [7:0]    host_idx, fill_first, fill_last, pal_waddr;
   logic [23:0]   host_rgb, fill_rgb, pal_wdata;
   logic [AW:0]   fifo_level;

   palette_write_ctrl #(.FIFO_AW(AW)) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .de(de), .blank_only(blank_only),
      .host_valid(host_valid), .host_ready(host_ready), .host_idx(host_idx), .host_rgb(host_rgb),
      .fill_start(fill_start), .fill_first(fill_first), .fill_last(fill_last), .fill_rgb(fill_rgb),
      .fill_busy(fill_busy), .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
      .fifo_level(fifo_level)
   );

   always #5 clk_pix = ~clk_pix;

   typedef struct {logic [7:0] a; logic [23:0] d; int c;} wr_t;

   int   errors = 0, checks = 0, cyc = 0, gate_viol = 0, fall_cyc = -1, push_cyc = 0;
   wr_t  got[$];
   logic busy_prev = 1'b0, de_prev = 1'b0, bo_prev = 1'b0;

   always @(posedge clk_pix) cyc <= cyc + 1;

   // Monitor: log every palette write and flag any that came from an active-video grant cycle.
   always @(negedge clk_pix) begin
      if (!rst_pix && pal_we) begin
         got.push_back('{pal_waddr, pal_wdata, cyc});
         if (bo_prev && de_prev) gate_viol++;
      end
      if (busy_prev && !fill_busy) fall_cyc = cyc;
      busy_prev = fill_busy;
      de_prev   = de;
      bo_prev   = blank_only;
   end

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic push(input logic [7:0] idx, input logic [23:0] rgb);
      logic ok;
      int   n;
      host_valid = 1'b1; host_idx = idx; host_rgb = rgb; n = 0;
      do begin
         ok = host_ready;
         tick();
         n++;
      end while (!ok && n < 500);
      checks++;
      if (!ok) begin errors++; $display("FAIL push_timeout idx=%0d", idx); end
      push_cyc = cyc;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin tick(); k++; end
      repeat (4) tick();
      checks++;
      if (got.size() !== n) begin errors++; $display("FAIL write_count got=%0d expected=%0d", got.size(), n); end
   endtask

   task automatic do_reset();
      rst_pix = 1'b1; host_valid = 1'b0; fill_start = 1'b0; de = 1'b0; blank_only = 1'b0;
      tick(); tick();
      rst_pix = 1'b0;
      tick();
      got.delete(); fall_cyc = -1; gate_viol = 0;
   endtask

   task automatic compare_stream(input string name, input wr_t exp[$]);
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i].a !== exp[i].a || got[i].d !== exp[i].d) begin
            errors++;
            $display("FAIL %s[%0d] got=%0d/%h expected=%0d/%h", name, i, got[i].a, got[i].d, exp[i].a, exp[i].d);
         end
      end
   endtask

   task automatic test_reset();
      rst_pix = 1'b1; host_valid = 1'b0; fill_start = 1'b0; de = 1'b0; blank_only = 1'b0;
      host_idx = 8'd0; host_rgb = 24'd0; fill_first = 8'd0; fill_last = 8'd0; fill_rgb = 24'd0;
      #2;
      checks += 6;
      if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready got=%b expected=1", host_ready); end
      if (fill_busy !== 1'b0) begin errors++; $display("FAIL reset_fill_busy got=%b expected=0", fill_busy); end
      if (pal_we !== 1'b0) begin errors++; $display("FAIL reset_pal_we got=%b expected=0", pal_we); end
      if (pal_waddr !== 8'd0) begin errors++; $display("FAIL reset_waddr got=%0d expected=0", pal_waddr); end
      if (pal_wdata !== 24'd0) begin errors++; $display("FAIL reset_wdata got=%h expected=0", pal_wdata); end
      if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d expected=0", fifo_level); end
      do_reset();
   endtask

   task automatic test_host_basic();
      wr_t exp[$];
      int  p0;
      got.delete(); blank_only = 1'b0; de = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) exp.push_back('{8'(i + 1), 24'($urandom()), 0});
      for (int i = 0; i < 3; i++) begin
         push(exp[i].a, exp[i].d);
         if (i == 0) p0 = push_cyc;
      end
      host_valid = 1'b0;
      wait_writes(3, 20);
      compare_stream("host_basic", exp);
      for (int i = 0; i < got.size() && i < 3; i++) begin
         checks++;
         if (got[i].c !== p0 + 1 + i) begin errors++; $display("FAIL host_latency[%0d] got=%0d expected=%0d", i, got[i].c, p0 + 1 + i); end
      end
      checks++;
      if (fifo_level !== 5'd0) begin errors++; $display("FAIL host_basic_level got=%0d expected=0", fifo_level); end
   endtask

   task automatic test_fifo_full();
      wr_t exp[$];
      got.delete(); blank_only = 1'b1; de = 1'b1;
      for (int i = 0; i < 17; i++) exp.push_back('{8'($urandom()), 24'($urandom()), 0});
      for (int i = 0; i < 16; i++) push(exp[i].a, exp[i].d);
      host_valid = 1'b1; host_idx = exp[16].a; host_rgb = exp[16].d;
      repeat (3) tick();
      checks += 3;
      if (host_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b expected=0", host_ready); end
      if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got=%0d expected=16", fifo_level); end
      if (got.size() !== 0) begin errors++; $display("FAIL full_gated_writes got=%0d expected=0", got.size()); end
      de = 1'b0;
      push(exp[16].a, exp[16].d);
      host_valid = 1'b0;
      wait_writes(17, 100);
      compare_stream("fifo_full", exp);
   endtask

   task automatic test_fill_wrap();
      wr_t exp[$];
      logic [7:0] first_v, last_v;
      logic [23:0] rgb_v;
      got.delete(); fall_cyc = -1; blank_only = 1'b0; de = 1'b1;
      first_v = 8'd250; last_v = 8'd3; rgb_v = 24'hFF0000;
      for (int k = 0; k <= int'(8'(last_v - first_v)); k++) exp.push_back('{8'(int'(first_v) + k), rgb_v, 0});
      fill_first = first_v; fill_last = last_v; fill_rgb = rgb_v; fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      checks++;
      if (fill_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_rise got=%b expected=1", fill_busy); end
      tick(); tick();
      fill_first = 8'd10; fill_last = 8'd20; fill_rgb = 24'($urandom()); fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      wait_writes(10, 40);
      compare_stream("fill_wrap", exp);
      checks++;
      if (got.size() > 0 && fall_cyc !== got[got.size() - 1].c) begin
         errors++; $display("FAIL fill_busy_fall got=%0d expected=%0d", fall_cyc, got[got.size() - 1].c);
      end
   endtask

   task automatic test_contention();
      wr_t hq[$], fq[$], exp[$];
      logic [23:0] frgb;
      bit turn_host;
      do_reset();
      blank_only = 1'b0; de = 1'($urandom_range(0, 1));
      frgb = 24'($urandom());
      for (int i = 0; i < 4; i++) hq.push_back('{8'(100 + i), 24'($urandom()), 0});
      for (int k = 0; k < 8; k++) fq.push_back('{8'(k), frgb, 0});
      turn_host = 1'b1;
      while (hq.size() > 0 && fq.size() > 0) begin
         if (turn_host) exp.push_back(hq.pop_front()); else exp.push_back(fq.pop_front());
         turn_host = !turn_host;
      end
      while (hq.size() > 0) exp.push_back(hq.pop_front());
      while (fq.size() > 0) exp.push_back(fq.pop_front());
      fill_first = 8'd0; fill_last = 8'd7; fill_rgb = frgb; fill_start = 1'b1;
      push(8'd100, exp[0].d);
      fill_start = 1'b0;
      for (int i = 1; i < 4; i++) push(8'(100 + i), exp[2 * i].d);
      host_valid = 1'b0;
      wait_writes(12, 60);
      compare_stream("contention", exp);
   endtask

   task automatic test_gated_fill();
      wr_t exp[$];
      logic [7:0] first_v;
      logic [23:0] rgb_v;
      int n;
      got.delete(); gate_viol = 0; blank_only = 1'b1; de = 1'b1;
      first_v = 8'($urandom()); rgb_v = 24'($urandom());
      for (int k = 0; k < 20; k++) exp.push_back('{8'(int'(first_v) + k), rgb_v, 0});
      fill_first = first_v; fill_last = 8'(int'(first_v) + 19); fill_rgb = rgb_v; fill_start = 1'b1;
      tick();
      fill_start = 1'b0; n = 1;
      while (fill_busy && n < 300) begin
         de = ((n / 5) % 2 == 0) ? 1'b1 : 1'b0;
         tick();
         n++;
      end
      de = 1'b0;
      wait_writes(20, 10);
      compare_stream("gated_fill", exp);
      checks++;
      if (gate_viol !== 0) begin errors++; $display("FAIL gated_write_in_active got=%0d expected=0", gate_viol); end
   endtask

   task automatic test_reset_mid();
      got.delete(); blank_only = 1'b1; de = 1'b1;
      for (int i = 0; i < 5; i++) push(8'($urandom()), 24'($urandom()));
      host_valid = 1'b0;
      fill_first = 8'd0; fill_last = 8'd30; fill_rgb = 24'($urandom()); fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      tick();
      checks += 2;
      if (fifo_level !== 5'd5) begin errors++; $display("FAIL pre_reset_level got=%0d expected=5", fifo_level); end
      if (fill_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%b expected=1", fill_busy); end
      rst_pix = 1'b1;
      #1;
      checks += 6;
      if (pal_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we got=%b expected=0", pal_we); end
      if (pal_waddr !== 8'd0) begin errors++; $display("FAIL mid_reset_waddr got=%0d expected=0", pal_waddr); end
      if (pal_wdata !== 24'd0) begin errors++; $display("FAIL mid_reset_wdata got=%h expected=0", pal_wdata); end
      if (host_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b expected=1", host_ready); end
      if (fill_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b expected=0", fill_busy); end
      if (fifo_level !== 5'd0) begin errors++; $display("FAIL mid_reset_level got=%0d expected=0", fifo_level); end
      tick();
      rst_pix = 1'b0; blank_only = 1'b0; de = 1'b0;
      got.delete();
      repeat (30) tick();
      checks += 3;
      if (got.size() !== 0) begin errors++; $display("FAIL post_reset_writes got=%0d expected=0", got.size()); end
      if (fill_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b expected=0", fill_busy); end
      if (fifo_level !== 5'd0) begin errors++; $display("FAIL post_reset_level got=%0d expected=0", fifo_level); end
   endtask

   initial begin
      test_reset();
      test_host_basic();
      test_fifo_full();
      test_fill_wrap();
      test_contention();
      test_gated_fill();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end
endmodule
